obuf_accum: RTL and testbench

Banked output buffer that accumulates signed partial sums. Each of NUM_BANKS independent banks has one write port that either overwrites or adds into an ACC_WIDTH-wide entry, and one read port with registered output. The write path is a two-stage read-modify-write pipeline with forwarding, and a built-in clear sequencer zeroes every bank without a software sweep. It sits between the systolic array output and the post-processing/store path, and is the parametrised successor of the plain banked output buffer.

---
 rtl/obuf_accum.sv | 189 ++++++++++++++++++
 tb/tb_obuf_accum.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obuf_accum.sv
// obuf_accum -- banked accumulating output buffer.
//
// NUM_BANKS independent banks of BUFFER_DEPTH x ACC_WIDTH signed entries.
// Each bank has one write port (overwrite or accumulate, two-stage
// read-modify-write with S2->S1 forwarding) and one read port with a
// registered output. A clear sequencer zeroes every entry of every bank.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   bs_write_req      per-bank write strobe
//   bs_write_accum    per-bank mode: 1 = add into entry, 0 = overwrite
//   bs_write_addr     per-bank write address, bank n at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   bs_write_data     per-bank signed partial sum, bank n at [n*DATA_WIDTH +: DATA_WIDTH]
//   bs_read_req       per-bank read strobe
//   bs_read_addr      per-bank read address
//   bs_read_data      per-bank registered read data, bank n at [n*ACC_WIDTH +: ACC_WIDTH]
//   bs_read_valid     per-bank read-data valid (one cycle after the request)
//   clear_start       pulse: zero all entries of all banks
//   clear_busy        clear sequence in progress
module obuf_accum #(
  parameter int NUM_BANKS    = 64,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 64,
  parameter int SATURATE     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_BANKS-1:0]            bs_write_req,
  input  logic [NUM_BANKS-1:0]            bs_write_accum,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] bs_write_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bs_write_data,
  input  logic [NUM_BANKS-1:0]            bs_read_req,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] bs_read_addr,
  output logic [NUM_BANKS*ACC_WIDTH-1:0]  bs_read_data,
  output logic [NUM_BANKS-1:0]            bs_read_valid,
  input  logic                            clear_start,
  output logic                            clear_busy
);

  localparam logic [ADDR_WIDTH:0]    DEPTH     = (ADDR_WIDTH+1)'(BUFFER_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(BUFFER_DEPTH - 1);
  localparam logic [ACC_WIDTH-1:0]   ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]   ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_enable;
  logic                  clear_we;

  // Clear sequencer. WAIT gives a write accepted alongside clear_start one
  // cycle to commit before the sweep starts, so the sweep always wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:  if (clear_start) state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // so the order of statements in sequential blocks never matters.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clear_busy = (state_q != ST_IDLE);
  assign wr_enable  = (state_q == ST_IDLE);
  assign clear_we   = (state_q == ST_CLEAR);

  for (genvar n = 0; n < NUM_BANKS; n++) begin : g_bank
    logic [ACC_WIDTH-1:0]  mem [BUFFER_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_in_range, rd_in_range;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_accum_q, s1_accum_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [ACC_WIDTH-1:0]  s1_old_q,   s1_old_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q,  s2_addr_d;
    logic [ACC_WIDTH-1:0]  s2_acc_q,   s2_acc_d;

    logic                  rd_valid_q, rd_valid_d;
    logic [ACC_WIDTH-1:0]  rd_data_q,  rd_data_d;

    logic [ACC_WIDTH-1:0]  old_fwd;
    logic [ACC_WIDTH:0]    old_ext, data_ext, sum;
    logic [ACC_WIDTH-1:0]  new_val;

    assign wr_addr     = bs_write_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data     = bs_write_data[n*DATA_WIDTH +: DATA_WIDTH];
    assign rd_addr     = bs_read_addr[n*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH);

    always_comb begin
      // S1: capture the request and the stored value it will modify.
      // Out-of-range writes never become valid, so they change nothing.
      s1_valid_d = bs_write_req[n] && wr_in_range && wr_enable;
      s1_accum_d = bs_write_accum[n];
      s1_addr_d  = wr_addr;
      s1_data_d  = wr_data;
      s1_old_d   = wr_in_range ? mem[wr_addr] : '0;

      // The entry S2 is committing this edge is newer than what S1 read.
      old_fwd  = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_acc_q : s1_old_q;
      old_ext  = {old_fwd[ACC_WIDTH-1], old_fwd};
      data_ext = {{(ACC_WIDTH+1-DATA_WIDTH){s1_data_q[DATA_WIDTH-1]}}, s1_data_q};
      sum      = old_ext + data_ext;

      if (!s1_accum_q)
        new_val = data_ext[ACC_WIDTH-1:0];
      else if ((SATURATE != 0) && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]))
        new_val = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else
        new_val = sum[ACC_WIDTH-1:0];

      // The clear sweep overwrites entries behind S2's back, so S2 must
      // not forward stale data into anything that follows it.
      s2_valid_d = s1_valid_q && !clear_we;
      s2_addr_d  = s1_addr_q;
      s2_acc_d   = new_val;

      rd_valid_d = bs_read_req[n];
      rd_data_d  = rd_data_q;
      if (bs_read_req[n]) rd_data_d = rd_in_range ? mem[rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
      s1_accum_q <= s1_accum_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s1_old_q   <= s1_old_d;
      s2_addr_q  <= s2_addr_d;
      s2_acc_q   <= s2_acc_d;
      if (reset) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s2_valid_q <= s2_valid_d;
        rd_valid_q <= rd_valid_d;
        rd_data_q  <= rd_data_d;
      end
    end

    // NOTE: the storage array has no reset; contents are undefined until
    // written or swept, which keeps it mappable onto RAM macros.
    // Writes are suppressed on a reset edge so an interrupted sweep leaves
    // the remaining entries untouched.
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (clear_we)        mem[cnt_q]     <= '0;
        else if (s1_valid_q) mem[s1_addr_q] <= new_val;
      end
    end

    assign bs_read_data[n*ACC_WIDTH +: ACC_WIDTH] = rd_data_q;
    assign bs_read_valid[n]                       = rd_valid_q;
  end

endmodule

// File: tb/tb_obuf_accum.sv
// Testbench for obuf_accum. Three instances:
//   dut_a : default configuration (64 banks, 32-bit entries, saturating, depth 64)
//   dut_b : 2 banks, 20-bit entries, saturating, depth 64
//   dut_c : 2 banks, 20-bit entries, wrapping, depth 48
// dut_b and dut_c share every input so one stimulus shows both arithmetic
// modes and the out-of-range rule side by side. Read results go through a
// scoreboard queue: expectations are pushed when a read is driven and
// popped when the matching bs_read_valid appears one cycle later.
module tb_obuf_accum;

  localparam int NB_A  = 64;
  localparam int NB_S  = 2;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int ACC_A = 32;
  localparam int ACC_S = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [NB_A-1:0]       a_wr_req, a_wr_accum, a_rd_req, a_rd_valid;
  logic [NB_A*AW-1:0]    a_wr_addr, a_rd_addr;
  logic [NB_A*DW-1:0]    a_wr_data;
  logic [NB_A*ACC_A-1:0] a_rd_data;
  logic                  a_clear, a_busy;

  logic [NB_S-1:0]       bc_wr_req, bc_wr_accum, bc_rd_req, b_rd_valid, c_rd_valid;
  logic [NB_S*AW-1:0]    bc_wr_addr, bc_rd_addr;
  logic [NB_S*DW-1:0]    bc_wr_data;
  logic [NB_S*ACC_S-1:0] b_rd_data, c_rd_data;
  logic                  bc_clear, b_busy, c_busy;

  obuf_accum #(
    .NUM_BANKS(NB_A), .DATA_WIDTH(DW), .ACC_WIDTH(ACC_A),
    .ADDR_WIDTH(AW), .BUFFER_DEPTH(64), .SATURATE(1)
  ) dut_a (
    .clk(clk), .reset(reset),
    .bs_write_req(a_wr_req), .bs_write_accum(a_wr_accum),
    .bs_write_addr(a_wr_addr), .bs_write_data(a_wr_data),
    .bs_read_req(a_rd_req), .bs_read_addr(a_rd_addr),
    .bs_read_data(a_rd_data), .bs_read_valid(a_rd_valid),
    .clear_start(a_clear), .clear_busy(a_busy)
  );

  obuf_accum #(
    .NUM_BANKS(NB_S), .DATA_WIDTH(DW), .ACC_WIDTH(ACC_S),
    .ADDR_WIDTH(AW), .BUFFER_DEPTH(64), .SATURATE(1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .bs_write_req(bc_wr_req), .bs_write_accum(bc_wr_accum),
    .bs_write_addr(bc_wr_addr), .bs_write_data(bc_wr_data),
    .bs_read_req(bc_rd_req), .bs_read_addr(bc_rd_addr),
    .bs_read_data(b_rd_data), .bs_read_valid(b_rd_valid),
    .clear_start(bc_clear), .clear_busy(b_busy)
  );

  obuf_accum #(
    .NUM_BANKS(NB_S), .DATA_WIDTH(DW), .ACC_WIDTH(ACC_S),
    .ADDR_WIDTH(AW), .BUFFER_DEPTH(48), .SATURATE(0)
  ) dut_c (
    .clk(clk), .reset(reset),
    .bs_write_req(bc_wr_req), .bs_write_accum(bc_wr_accum),
    .bs_write_addr(bc_wr_addr), .bs_write_data(bc_wr_data),
    .bs_read_req(bc_rd_req), .bs_read_addr(bc_rd_addr),
    .bs_read_data(c_rd_data), .bs_read_valid(c_rd_valid),
    .clear_start(bc_clear), .clear_busy(c_busy)
  );

  typedef struct {
    int          dut;
    int          bank;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic idle_inputs();
    a_wr_req = '0; a_wr_accum = '0; a_wr_addr = '0; a_wr_data = '0;
    a_rd_req = '0; a_rd_addr = '0; a_clear = 1'b0;
    bc_wr_req = '0; bc_wr_accum = '0; bc_wr_addr = '0; bc_wr_data = '0;
    bc_rd_req = '0; bc_rd_addr = '0; bc_clear = 1'b0;
  endtask

  task automatic wr_a(input int bank, input logic accum, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data);
    a_wr_req[bank]             = 1'b1;
    a_wr_accum[bank]           = accum;
    a_wr_addr[bank*AW +: AW]   = addr;
    a_wr_data[bank*DW +: DW]   = data;
  endtask

  task automatic rd_a(input int bank, input logic [AW-1:0] addr, input logic [31:0] exp_data);
    exp_t e;
    a_rd_req[bank]           = 1'b1;
    a_rd_addr[bank*AW +: AW] = addr;
    e.dut = 0; e.bank = bank; e.data = exp_data;
    exp_q.push_back(e);
  endtask

  task automatic wr_bc(input int bank, input logic accum, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    bc_wr_req[bank]            = 1'b1;
    bc_wr_accum[bank]          = accum;
    bc_wr_addr[bank*AW +: AW]  = addr;
    bc_wr_data[bank*DW +: DW]  = data;
  endtask

  // One bank per call and per cycle, so pops (dut_b then dut_c) match pushes.
  task automatic rd_bc(input int bank, input logic [AW-1:0] addr,
                       input logic [31:0] exp_b, input logic [31:0] exp_c);
    exp_t e;
    bc_rd_req[bank]           = 1'b1;
    bc_rd_addr[bank*AW +: AW] = addr;
    e.dut = 1; e.bank = bank; e.data = exp_b;
    exp_q.push_back(e);
    e.dut = 2; e.data = exp_c;
    exp_q.push_back(e);
  endtask

  // Advance one clock: inputs driven before the call are sampled at the
  // rising edge, outputs are inspected at the following falling edge.
  // Every read pushed before this edge must come back valid right now.
  task automatic tick();
    exp_t        e;
    logic        v;
    logic [31:0] got;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      for (int b = 0; b < NB_A; b++) begin
        if (d != 0 && b >= NB_S) break;
        case (d)
          0:       begin v = a_rd_valid[b]; got = a_rd_data[b*ACC_A +: ACC_A]; end
          1:       begin v = b_rd_valid[b]; got = {12'b0, b_rd_data[b*ACC_S +: ACC_S]}; end
          default: begin v = c_rd_valid[b]; got = {12'b0, c_rd_data[b*ACC_S +: ACC_S]}; end
        endcase
        if (v) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_valid dut=%0d bank=%0d got=%h required=no read", d, b, got);
          end else begin
            e = exp_q.pop_front();
            if (e.dut != d || e.bank != b || got !== e.data) begin
              failures++;
              $display("FAIL sb_read dut=%0d bank=%0d got=%h required dut=%0d bank=%0d data=%h",
                       d, b, got, e.dut, e.bank, e.data);
            end
          end
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_missing_valid pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    a_rd_req  = '1;
    bc_rd_req = '1;
    tick();
    checks++;
    if (a_rd_valid !== '0) begin failures++; $display("FAIL reset_valid_a got=%h required=0", a_rd_valid); end
    checks++;
    if (a_rd_data !== '0) begin failures++; $display("FAIL reset_data_a got=%0d set bits required=0", $countones(a_rd_data)); end
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy_a got=%b required=0", a_busy); end
    checks++;
    if (b_rd_valid !== '0 || c_rd_valid !== '0) begin
      failures++; $display("FAIL reset_valid_bc got=%b/%b required=0", b_rd_valid, c_rd_valid);
    end
    checks++;
    if (b_rd_data !== '0 || c_rd_data !== '0) begin
      failures++; $display("FAIL reset_data_bc got=%h/%h required=0", b_rd_data, c_rd_data);
    end
    checks++;
    if (b_busy !== 1'b0 || c_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy_bc got=%b/%b required=0", b_busy, c_busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_overwrite();
    wr_a(3, 1'b0, 6'd5, 16'd42);
    tick();
    tick();
    wr_a(3, 1'b0, 6'd5, 16'hFFF9);          // -7, sampled at edge E
    tick();
    rd_a(3, 6'd5, 32'd42);                  // edge E+1: still the old value
    tick();
    rd_a(3, 6'd5, 32'hFFFF_FFF9);           // edge E+2: sees the write
    tick();
    tick();
    checks++;
    if (a_rd_valid[3] !== 1'b0) begin failures++; $display("FAIL overwrite_valid_drop got=%b required=0", a_rd_valid[3]); end
    checks++;
    if (a_rd_data[3*ACC_A +: ACC_A] !== 32'hFFFF_FFF9) begin
      failures++; $display("FAIL overwrite_data_hold got=%h required=fffffff9", a_rd_data[3*ACC_A +: ACC_A]);
    end
  endtask

  task automatic test_back_to_back();
    // All banks, addr 10: overwrite 100+b, then +1, +2, +3 on consecutive edges.
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < NB_A; b++)
        wr_a(b, s != 0, 6'd10, (s == 0) ? DW'(100 + b) : DW'(s));
      tick();
    end
    tick();
    for (int b = 0; b < NB_A; b++) rd_a(b, 6'd10, 32'(106 + b));
    tick();
    // Bank 7, addr 11: one-cycle gap then back-to-back negative accumulation.
    wr_a(7, 1'b0, 6'd11, 16'hFFCE);         // -50
    tick();
    tick();
    wr_a(7, 1'b1, 6'd11, 16'hFFEC);         // -20
    tick();
    wr_a(7, 1'b1, 6'd11, 16'd5);
    tick();
    tick();
    rd_a(7, 6'd11, 32'hFFFF_FFBF);          // -65
    tick();
  endtask

  task automatic test_saturate();
    // 16 x 0x7FFF = 0x7FFF0; one more 0x7FFF overflows 20 bits.
    // 16 x -0x8000 = -2**19 exactly; one more -1 underflows.
    for (int s = 0; s < 17; s++) begin
      wr_bc(0, s != 0, 6'd20, 16'h7FFF);
      wr_bc(1, s != 0, 6'd20, (s == 16) ? 16'hFFFF : 16'h8000);
      tick();
    end
    tick();
    rd_bc(0, 6'd20, 32'h7FFFF, 32'h87FEF);
    tick();
    rd_bc(1, 6'd20, 32'h80000, 32'h7FFFF);
    tick();
  endtask

  task automatic test_out_of_range();
    // addr 50 is valid in dut_b (depth 64), out of range in dut_c (depth 48).
    wr_bc(0, 1'b0, 6'd50, 16'd123);
    wr_bc(1, 1'b0, 6'd47, 16'd5);
    tick();
    wr_bc(0, 1'b1, 6'd50, 16'd1);
    tick();
    wr_bc(0, 1'b1, 6'd50, 16'd1);
    tick();
    tick();
    rd_bc(0, 6'd50, 32'd125, 32'd0);
    tick();
    rd_bc(1, 6'd47, 32'd5, 32'd5);
    tick();
  endtask

  task automatic test_clear();
    logic exp_busy;
    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < NB_A; b++) wr_a(b, 1'b0, AW'(k), 16'h0055);
      tick();
    end
    a_clear = 1'b1;
    for (int b = 0; b < NB_A; b++) wr_a(b, 1'b0, 6'd0, 16'd9);
    tick();                                  // edge E
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL clear_busy_start got=%b required=1", a_busy); end
    for (int k = 1; k <= 65; k++) begin      // inputs sampled at edge E+k
      if (k == 2) begin
        rd_a(0, 6'd63, 32'h55);              // not yet swept
        rd_a(1, 6'd0, 32'd9);                // write from edge E committed, not yet zeroed
      end
      if (k == 3) rd_a(1, 6'd0, 32'd0);
      if (k == 10) begin
        wr_a(0, 1'b0, 6'd5, 16'h0077);
        a_clear = 1'b1;
      end
      if (k == 65) begin
        rd_a(0, 6'd63, 32'h55);              // zeroed on this very edge
        wr_a(2, 1'b0, 6'd4, 16'h0066);       // last ignored edge
      end
      tick();
      exp_busy = (k <= 64);
      checks++;
      if (a_busy !== exp_busy) begin
        failures++; $display("FAIL clear_busy k=%0d got=%b required=%b", k, a_busy, exp_busy);
      end
    end
    wr_a(2, 1'b0, 6'd7, 16'h0033);           // edge E+66: accepted again
    tick();
    tick();
    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < NB_A; b++)
        rd_a(b, AW'(k), (k == 7 && b == 2) ? 32'h33 : 32'h0);
      tick();
    end
  endtask

  task automatic test_reset_mid_clear();
    wr_a(0, 1'b0, 6'd60, 16'h0044);
    tick();
    tick();
    a_clear = 1'b1;
    tick();                                  // edge E
    tick();
    rd_a(0, 6'd60, 32'h44);
    tick();
    reset    = 1'b1;
    a_rd_req = '1;
    tick();
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL midclear_busy got=%b required=0", a_busy); end
    checks++;
    if (a_rd_valid !== '0) begin failures++; $display("FAIL midclear_valid got=%h required=0", a_rd_valid); end
    checks++;
    if (a_rd_data !== '0) begin failures++; $display("FAIL midclear_data got=%0d set bits required=0", $countones(a_rd_data)); end
    reset = 1'b0;
    tick();
    rd_a(0, 6'd60, 32'h44);                  // far from the sweep point: kept
    tick();
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL midclear_busy_after got=%b required=0", a_busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_overwrite();
    test_back_to_back();
    test_saturate();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
